// File: rtl/tt_sweep_ctrl.sv
// Sweeps all 16 input vectors of a 4-input gate and grades its truth table against EXPECTED_TT.
// Latency: 16*(SETTLE_CYCLES+1)+2 cycles from accepted start to the done pulse.
// Backpressure: none; start is a single-cycle request that is ignored while busy, and abort cancels a sweep.
module tt_sweep_ctrl #(
   parameter int          SETTLE_CYCLES = 2,
   parameter logic [15:0] EXPECTED_TT   = 16'h240F
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        dut_out,
   output logic [3:0]  dut_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] tt_captured,
   output logic [15:0] mismatch_mask,
   output logic [4:0]  fail_count,
   output logic [3:0]  first_fail_idx,
   output logic        pass
);

   typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, EVAL, DONE} state_t;

   // Last value of the settle counter before moving on to the capture cycle
   localparam logic [7:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;
   // With no settle time, every vector starts directly in its capture cycle
   localparam state_t VEC_ENTRY = (SETTLE_CYCLES > 0) ? SETTLE : CAPTURE;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  index;
   logic [7:0]  settle_cnt;
   logic        accept;
   logic [15:0] eval_mask;
   logic [4:0]  eval_count;
   logic [3:0]  eval_first;

   assign accept = (state == IDLE) && start && !abort;
   assign dut_in = index;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; abort takes priority in every active state except DONE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = VEC_ENTRY;
         SETTLE:  if (abort) state_nxt = IDLE;
                  else if (settle_cnt == SETTLE_LAST) state_nxt = CAPTURE;
         CAPTURE: if (abort) state_nxt = IDLE;
                  else if (index == 4'd15) state_nxt = EVAL;
                  else state_nxt = VEC_ENTRY;
         EVAL:    state_nxt = abort ? IDLE : DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs decoded from the current state
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // Grading of the complete captured table: mismatch bits, their count and the lowest failing index
   always_comb begin
      eval_mask  = tt_captured ^ EXPECTED_TT;
      eval_count = 5'd0;
      eval_first = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (eval_mask[i]) begin
            eval_count = eval_count + 5'd1;
            eval_first = 4'(i);
         end
      end
   end

   // Vector index, settle timer, capture and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         index          <= 4'd0;
         settle_cnt     <= 8'd0;
         tt_captured    <= 16'd0;
         mismatch_mask  <= 16'd0;
         fail_count     <= 5'd0;
         first_fail_idx <= 4'd0;
         pass           <= 1'b0;
      end else begin
         if (state == SETTLE && state_nxt == SETTLE) settle_cnt <= settle_cnt + 8'd1;
         else                                         settle_cnt <= 8'd0;

         if (accept) begin
            index          <= 4'd0;
            tt_captured    <= 16'd0;
            mismatch_mask  <= 16'd0;
            fail_count     <= 5'd0;
            first_fail_idx <= 4'd0;
            pass           <= 1'b0;
         end

         // Index saturates at 15 so the last vector stays on dut_in after the sweep
         if (state == CAPTURE && !abort) begin
            tt_captured[index] <= dut_out;
            if (index != 4'd15) index <= index + 4'd1;
         end

         if (state == EVAL && !abort) begin
            mismatch_mask  <= eval_mask;
            fail_count     <= eval_count;
            first_fail_idx <= eval_first;
            pass           <= (eval_mask == 16'd0);
         end
      end
   end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: one instance with the default settle time and one with zero settle time.
// Each instance drives a behavioural gate (a truth-table lookup) and is checked cycle by cycle.
module tb_tt_sweep_ctrl;

   localparam logic [15:0] EXP = 16'h240F;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        st[2];
   logic        ab[2];
   logic        gout[2];
   logic [15:0] gate_tt[2];
   logic [3:0]  din[2];
   logic        bsy[2];
   logic        dn[2];
   logic [15:0] ttc[2];
   logic [15:0] mmk[2];
   logic [4:0]  fcn[2];
   logic [3:0]  ffi[2];
   logic        ps[2];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign gout[0] = gate_tt[0][din[0]];
   assign gout[1] = gate_tt[1][din[1]];

   tt_sweep_ctrl #(.SETTLE_CYCLES(2), .EXPECTED_TT(EXP)) dut (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]), .dut_out(gout[0]),
      .dut_in(din[0]), .busy(bsy[0]), .done(dn[0]), .tt_captured(ttc[0]),
      .mismatch_mask(mmk[0]), .fail_count(fcn[0]), .first_fail_idx(ffi[0]), .pass(ps[0]));

   tt_sweep_ctrl #(.SETTLE_CYCLES(0), .EXPECTED_TT(EXP)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]), .dut_out(gout[1]),
      .dut_in(din[1]), .busy(bsy[1]), .done(dn[1]), .tt_captured(ttc[1]),
      .mismatch_mask(mmk[1]), .fail_count(fcn[1]), .first_fail_idx(ffi[1]), .pass(ps[1]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int settle_of(input int sel);
      return (sel == 0) ? 2 : 0;
   endfunction

   // Reference grading: compare a gate's table against the intended function
   function automatic logic [15:0] ref_mask(input logic [15:0] tt);
      return tt ^ EXP;
   endfunction

   function automatic logic [3:0] ref_first(input logic [15:0] m);
      for (int i = 0; i < 16; i++) if (m[i]) return 4'(i);
      return 4'd0;
   endfunction

   // One sweep on instance sel with gate table tt; poke = offset of a stray start pulse,
   // abrt = offset at which abort is raised (-1 disables either)
   task automatic run_sweep(input int sel, input logic [15:0] tt, input int poke, input int abrt, input string name);
      int per, d;
      logic [15:0] m;
      per = settle_of(sel) + 1;
      d   = 16 * per + 1;
      m   = ref_mask(tt);
      gate_tt[sel] = tt;
      st[sel] = 1'b1;
      tick();
      st[sel] = 1'b0;
      for (int off = 0; off <= d + 1; off++) begin
         if (abrt >= 0 && off > abrt) begin
            checks++;
            if (bsy[sel] !== 1'b0 || dn[sel] !== 1'b0 || ps[sel] !== 1'b0) begin
               errors++;
               $display("FAIL %s aborted off=%0d busy=%b done=%b pass=%b required 0/0/0", name, off, bsy[sel], dn[sel], ps[sel]);
            end
         end else begin
            logic [3:0] want_in;
            want_in = (off < 16 * per) ? 4'(off / per) : 4'd15;
            checks++;
            if (din[sel] !== want_in || dn[sel] !== (off == d) || bsy[sel] !== (off <= d)) begin
               errors++;
               $display("FAIL %s seq off=%0d dut_in=%0d busy=%b done=%b required %0d/%b/%b",
                        name, off, din[sel], bsy[sel], dn[sel], want_in, (off <= d), (off == d));
            end
         end
         if (off == d && abrt < 0) begin
            checks++;
            if (ttc[sel] !== tt || mmk[sel] !== m || fcn[sel] !== 5'($countones(m)) ||
                ffi[sel] !== ref_first(m) || ps[sel] !== (m == 16'd0)) begin
               errors++;
               $display("FAIL %s results tt=%h mm=%h fc=%0d ff=%0d pass=%b required %h/%h/%0d/%0d/%b",
                        name, ttc[sel], mmk[sel], fcn[sel], ffi[sel], ps[sel],
                        tt, m, $countones(m), ref_first(m), (m == 16'd0));
            end
         end
         st[sel] = (off == poke);
         ab[sel] = (off == abrt);
         tick();
      end
      st[sel] = 1'b0;
      ab[sel] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         st[0] = i[0];
         st[1] = i[0];
         tick();
      end
      for (int s = 0; s < 2; s++) begin
         checks++;
         if ({din[s], bsy[s], dn[s], ttc[s], mmk[s], fcn[s], ffi[s], ps[s]} !== '0) begin
            errors++;
            $display("FAIL reset_outputs inst=%0d dut_in=%0d busy=%b done=%b tt=%h mm=%h fc=%0d ff=%0d pass=%b required all 0",
                     s, din[s], bsy[s], dn[s], ttc[s], mmk[s], fcn[s], ffi[s], ps[s]);
         end
      end
      st[0] = 1'b0;
      st[1] = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (bsy[0] !== 1'b0 || dn[0] !== 1'b0 || bsy[1] !== 1'b0 || dn[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d busy=%b%b done=%b%b required 00/00", i, bsy[0], bsy[1], dn[0], dn[1]);
         end
      end
   endtask

   task automatic test_golden();
      run_sweep(0, EXP, -1, -1, "golden");
      // Results and last vector hold once idle again
      repeat (3) tick();
      checks++;
      if (dn[0] !== 1'b0 || ps[0] !== 1'b1 || din[0] !== 4'd15 || ttc[0] !== EXP) begin
         errors++;
         $display("FAIL golden_hold done=%b pass=%b dut_in=%0d tt=%h required 0/1/15/%h", dn[0], ps[0], din[0], ttc[0], EXP);
      end
   endtask

   task automatic test_faults();
      logic [15:0] t;
      t = EXP;
      t[5] = ~t[5];
      run_sweep(0, t, -1, -1, "flip5");
      checks++;
      if (ttc[0] !== 16'h242F || mmk[0] !== 16'h0020 || fcn[0] !== 5'd1 || ffi[0] !== 4'd5 || ps[0] !== 1'b0) begin
         errors++;
         $display("FAIL flip5_values tt=%h mm=%h fc=%0d ff=%0d pass=%b required 242f/0020/1/5/0", ttc[0], mmk[0], fcn[0], ffi[0], ps[0]);
      end
      run_sweep(0, 16'h0000, -1, -1, "stuck0");
      checks++;
      if (mmk[0] !== 16'h240F || fcn[0] !== 5'd6 || ffi[0] !== 4'd0 || ps[0] !== 1'b0) begin
         errors++;
         $display("FAIL stuck0_values mm=%h fc=%0d ff=%0d pass=%b required 240f/6/0/0", mmk[0], fcn[0], ffi[0], ps[0]);
      end
   endtask

   task automatic test_abort();
      run_sweep(0, EXP, -1, 21, "abort_at7");
      run_sweep(0, EXP, -1, -1, "after_abort");
   endtask

   task automatic test_handshake();
      logic [15:0] t;
      run_sweep(0, EXP, 10, -1, "start_midsweep");
      t = 16'h8001;
      run_sweep(0, t, -1, -1, "pre_start_abort");
      st[0] = 1'b1;
      ab[0] = 1'b1;
      tick();
      st[0] = 1'b0;
      ab[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bsy[0] !== 1'b0 || dn[0] !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle cyc=%0d busy=%b done=%b required 0/0", i, bsy[0], dn[0]);
         end
         tick();
      end
      checks++;
      if (ttc[0] !== t || mmk[0] !== (t ^ EXP) || fcn[0] !== 5'($countones(t ^ EXP)) || ffi[0] !== ref_first(t ^ EXP)) begin
         errors++;
         $display("FAIL start_abort_keep tt=%h mm=%h fc=%0d ff=%0d required %h/%h/%0d/%0d",
                  ttc[0], mmk[0], fcn[0], ffi[0], t, t ^ EXP, $countones(t ^ EXP), ref_first(t ^ EXP));
      end
   endtask

   task automatic test_reset_midsweep();
      gate_tt[0] = EXP;
      st[0] = 1'b1;
      tick();
      st[0] = 1'b0;
      repeat (27) tick();
      checks++;
      if (din[0] !== 4'd9) begin
         errors++;
         $display("FAIL reset_mid_index dut_in=%0d required 9", din[0]);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({din[0], bsy[0], dn[0], ttc[0], mmk[0], fcn[0], ffi[0], ps[0]} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs dut_in=%0d busy=%b done=%b tt=%h pass=%b required all 0", din[0], bsy[0], dn[0], ttc[0], ps[0]);
      end
      tick();
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         checks++;
         if (bsy[0] !== 1'b0 || dn[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle busy=%b done=%b required 0/0", bsy[0], dn[0]);
         end
      end
   endtask

   task automatic test_settle0();
      run_sweep(1, EXP, -1, -1, "s0_golden");
      run_sweep(1, 16'(~EXP), -1, -1, "s0_inverted");
   endtask

   task automatic test_random();
      for (int n = 0; n < 6; n++) begin
         logic [15:0] t;
         t = 16'($urandom);
         if (n[0]) t = EXP ^ (16'd1 << $urandom_range(15, 0));
         run_sweep(n % 2, t, (n == 2) ? int'($urandom_range(30, 1)) : -1, -1, "random");
      end
   endtask

   initial begin
      st[0] = 1'b0; st[1] = 1'b0;
      ab[0] = 1'b0; ab[1] = 1'b0;
      gate_tt[0] = EXP; gate_tt[1] = EXP;
      test_reset();
      test_golden();
      test_faults();
      test_abort();
      test_handshake();
      test_reset_midsweep();
      test_settle0();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
